fifo_arbiter: RTL and testbench

Controller that shares the 16-bit, 8-entry `fifo` between two write requesters and drains it into a single ready/valid consumer. It owns all `fifo` control inputs (DIN, WR, RD) and sits between the producer blocks and the downstream sink. It tracks FIFO occupancy with its own counter, so writes and reads never hit FULL or EMPTY in normal operation. `fifo` overrun and underrun indications are latched as sticky errors.

---
 rtl/fifo_arbiter_pkg.sv | 8 +
 rtl/fifo_arbiter_if.sv | 24 ++
 rtl/fifo_arbiter_rr_arb2.sv | 19 +
 rtl/fifo_arbiter.sv | 94 +++++++++
 tb/tb_fifo_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arbiter_pkg.sv
// fifo_arbiter_pkg: shared types and constants for the FIFO arbiter slice
package fifo_arbiter_pkg;
    typedef enum logic [1:0] {R_IDLE, R_PEND, R_HOLD} rd_state_e;
    localparam int ERR_OVER  = 0;
    localparam int ERR_UNDER = 1;
    localparam int DEF_DW    = 16;
    localparam int DEF_DEPTH = 8;
endpackage

// File: rtl/fifo_arbiter_if.sv
// fifo_arbiter_if: requester, FIFO-control, consumer and status signals of the arbiter
interface fifo_arbiter_if #(
    parameter int DW    = fifo_arbiter_pkg::DEF_DW,
    parameter int DEPTH = fifo_arbiter_pkg::DEF_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);
    logic          REQ0, REQ1, ACK0, ACK1;
    logic [DW-1:0] DAT0, DAT1;
    logic [DW-1:0] F_DIN, F_DOUT;
    logic          F_WR, F_RD, F_VALID, F_OVER, F_UNDER;
    logic [DW-1:0] M_DATA;
    logic          M_VALID, M_READY;
    logic          CLR_ERR;
    logic [1:0]    ERR;
    logic [CW-1:0] CNT;
    modport slave (
        input  REQ0, REQ1, DAT0, DAT1, F_DOUT, F_VALID, F_OVER, F_UNDER, M_READY, CLR_ERR,
        output ACK0, ACK1, F_DIN, F_WR, F_RD, M_DATA, M_VALID, ERR, CNT
    );
    modport master (
        output REQ0, REQ1, DAT0, DAT1, F_DOUT, F_VALID, F_OVER, F_UNDER, M_READY, CLR_ERR,
        input  ACK0, ACK1, F_DIN, F_WR, F_RD, M_DATA, M_VALID, ERR, CNT
    );
endinterface

// File: rtl/fifo_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant over an eligibility mask; pointer flips only on contention
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] elig_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);
    logic ptr_q, ptr_d;
    // grant the lone eligible requester, or the pointer's one when both compete
    always_comb begin
        gnt_o = !en_i ? 2'b00 : (&elig_i) ? (ptr_q ? 2'b10 : 2'b01) : elig_i;
        ptr_d = (en_i && (&elig_i)) ? ~ptr_q : ptr_q;
    end
    // pointer register, requester 0 favoured after reset
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: shares one FIFO between two writers and drains it to a ready/valid sink
module fifo_arbiter #(
    parameter int DW    = fifo_arbiter_pkg::DEF_DW,
    parameter int DEPTH = fifo_arbiter_pkg::DEF_DEPTH
) (
    input  logic           CLK,
    input  logic           RSTN,
    fifo_arbiter_if.slave  bus
);
    import fifo_arbiter_pkg::*;
    localparam int CW = $clog2(DEPTH + 1);

    rd_state_e     state_q, state_d;
    logic [1:0]    ack_q, ack_d, err_q, err_d, elig, gnt;
    logic          f_wr_q, f_wr_d, f_rd_q, f_rd_d, m_valid_q, m_valid_d;
    logic [DW-1:0] f_din_q, f_din_d, m_data_q, m_data_d;
    logic [CW-1:0] cnt_q, nxt;
    logic [CW:0]   nxt_w;
    logic          wr_ok;

    assign nxt   = cnt_q + CW'(f_wr_q) - CW'(f_rd_q);
    assign nxt_w = {1'b0, cnt_q} + (CW+1)'(f_wr_q) - (CW+1)'(f_rd_q);
    assign wr_ok = nxt < CW'(DEPTH);
    assign elig  = {bus.REQ1 & ~ack_q[1], bus.REQ0 & ~ack_q[0]};

    rr_arb2 u_arb (.clk_i(CLK), .rst_ni(RSTN), .elig_i(elig), .en_i(wr_ok), .gnt_o(gnt));

    // next-state for write grant, sticky errors and the read FSM
    always_comb begin
        ack_d            = gnt;
        f_wr_d           = |gnt;
        f_din_d          = gnt[1] ? bus.DAT1 : gnt[0] ? bus.DAT0 : f_din_q;
        err_d[ERR_OVER]  = bus.F_OVER  | (err_q[ERR_OVER]  & ~bus.CLR_ERR);
        err_d[ERR_UNDER] = bus.F_UNDER | (err_q[ERR_UNDER] & ~bus.CLR_ERR);
        state_d          = state_q;
        f_rd_d           = 1'b0;
        m_valid_d        = m_valid_q;
        m_data_d         = m_data_q;
        case (state_q)
            R_IDLE: if (nxt != '0) begin
                f_rd_d  = 1'b1;
                state_d = R_PEND;
            end
            R_PEND: if (bus.F_VALID) begin
                m_data_d  = bus.F_DOUT;
                m_valid_d = 1'b1;
                state_d   = R_HOLD;
            end
            R_HOLD: if (bus.M_READY) begin
                m_valid_d = 1'b0;
                f_rd_d    = nxt != '0;
                state_d   = (nxt != '0) ? R_PEND : R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    // all outputs and state registered; occupancy follows the projected count
    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            state_q   <= R_IDLE;
            ack_q     <= '0;
            err_q     <= '0;
            f_wr_q    <= 1'b0;
            f_rd_q    <= 1'b0;
            m_valid_q <= 1'b0;
            f_din_q   <= '0;
            m_data_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            f_wr_q    <= f_wr_d;
            f_rd_q    <= f_rd_d;
            m_valid_q <= m_valid_d;
            f_din_q   <= f_din_d;
            m_data_q  <= m_data_d;
            cnt_q     <= nxt;
        end

    // occupancy must stay within 0..DEPTH; an underflow wraps the wide sum above DEPTH
    assert property (@(posedge CLK) disable iff (!RSTN) nxt_w <= (CW+1)'(DEPTH));

    assign bus.ACK0    = ack_q[0];
    assign bus.ACK1    = ack_q[1];
    assign bus.F_DIN   = f_din_q;
    assign bus.F_WR    = f_wr_q;
    assign bus.F_RD    = f_rd_q;
    assign bus.M_DATA  = m_data_q;
    assign bus.M_VALID = m_valid_q;
    assign bus.ERR     = err_q;
    assign bus.CNT     = cnt_q;
endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: FIFO model, requester drivers, scoreboard and directed checks for fifo_arbiter
module tb_fifo_arbiter;
    import fifo_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fifo_arbiter_if #(.DW(16), .DEPTH(8)) bus ();
    fifo_arbiter #(.DW(16), .DEPTH(8)) dut (.CLK(clk), .RSTN(rstn), .bus(bus.slave));

    int errors = 0;
    int checks = 0;
    int acks = 0;
    int cyc = 0;
    int glog[$];
    int gcyc[$];
    logic [15:0] src0[$], src1[$], sb[$], fmem[$];
    logic [15:0] m_dout;
    logic m_valid, m_over, m_under, force_over, force_under;

    typedef struct {logic ov; logic un; logic clr; logic [1:0] err;} evec_t;
    evec_t ev[8];

    assign bus.F_DOUT  = m_dout;
    assign bus.F_VALID = m_valid;
    assign bus.F_OVER  = m_over | force_over;
    assign bus.F_UNDER = m_under | force_under;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack0"}, 32'(bus.ACK0), 0);
        chk({tag, "_ack1"}, 32'(bus.ACK1), 0);
        chk({tag, "_f_wr"}, 32'(bus.F_WR), 0);
        chk({tag, "_f_rd"}, 32'(bus.F_RD), 0);
        chk({tag, "_f_din"}, 32'(bus.F_DIN), 0);
        chk({tag, "_m_data"}, 32'(bus.M_DATA), 0);
        chk({tag, "_m_valid"}, 32'(bus.M_VALID), 0);
        chk({tag, "_err"}, 32'(bus.ERR), 0);
        chk({tag, "_cnt"}, 32'(bus.CNT), 0);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int i;
        for (i = 0; i < bound && (sb.size() != 0 || src0.size() != 0 || src1.size() != 0); i++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0 || src0.size() != 0 || src1.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d words still outstanding, required 0", name, sb.size());
        end
    endtask

    // 8-entry FIFO with registered DOUT/VALID and one-cycle OVER/UNDER pulses
    always @(posedge clk or negedge rstn)
        if (!rstn) begin
            fmem.delete();
            m_dout <= '0;
            m_valid <= 1'b0;
            m_over <= 1'b0;
            m_under <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            m_over <= 1'b0;
            m_under <= 1'b0;
            if (bus.F_RD) begin
                if (fmem.size() != 0) begin
                    m_dout <= fmem.pop_front();
                    m_valid <= 1'b1;
                end else m_under <= 1'b1;
            end
            if (bus.F_WR) begin
                if (fmem.size() < 8) fmem.push_back(bus.F_DIN);
                else m_over <= 1'b1;
            end
        end

    // requester 0: present next word once the previous one is acknowledged
    initial begin
        bus.REQ0 = 1'b0;
        bus.DAT0 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.REQ0 || bus.ACK0) begin
                if (src0.size() != 0) begin
                    bus.REQ0 = 1'b1;
                    bus.DAT0 = src0.pop_front();
                end else bus.REQ0 = 1'b0;
            end
        end
    end

    // requester 1
    initial begin
        bus.REQ1 = 1'b0;
        bus.DAT1 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.REQ1 || bus.ACK1) begin
                if (src1.size() != 0) begin
                    bus.REQ1 = 1'b1;
                    bus.DAT1 = src1.pop_front();
                end else bus.REQ1 = 1'b0;
            end
        end
    end

    // monitor: occupancy vs FIFO contents, grant log, consumer scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            chk("cnt_vs_fifo", 32'(bus.CNT), 32'(fmem.size()));
            if (bus.ACK0 || bus.ACK1) begin
                acks++;
                glog.push_back(bus.ACK1 ? 1 : 0);
                gcyc.push_back(cyc);
            end
            if (bus.M_VALID && bus.M_READY) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h with nothing expected", bus.M_DATA);
                end else chk("m_data", 32'(bus.M_DATA), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        ev[0] = '{1'b1, 1'b0, 1'b0, 2'b01};
        ev[1] = '{1'b0, 1'b0, 1'b0, 2'b01};
        ev[2] = '{1'b0, 1'b0, 1'b1, 2'b00};
        ev[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
        ev[4] = '{1'b0, 1'b0, 1'b0, 2'b10};
        ev[5] = '{1'b1, 1'b0, 1'b1, 2'b01};
        ev[6] = '{1'b0, 1'b0, 1'b1, 2'b00};
        ev[7] = '{1'b1, 1'b1, 1'b0, 2'b11};
        bus.M_READY = 1'b1;
        bus.CLR_ERR = 1'b0;
        force_over = 1'b0;
        force_under = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // single word: timing of ACK, CNT and consumer output
        src0.push_back(16'h1234);
        sb.push_back(16'h1234);
        @(negedge clk);
        chk("t1_ack0_early", 32'(bus.ACK0), 0);
        @(negedge clk);
        chk("t1_ack0", 32'(bus.ACK0), 1);
        chk("t1_f_wr", 32'(bus.F_WR), 1);
        chk("t1_f_din", 32'(bus.F_DIN), 32'h1234);
        @(negedge clk);
        chk("t1_cnt", 32'(bus.CNT), 1);
        chk("t1_ack0_pulse", 32'(bus.ACK0), 0);
        chk("t1_f_rd", 32'(bus.F_RD), 1);
        repeat (2) @(negedge clk);
        chk("t1_m_valid", 32'(bus.M_VALID), 1);
        chk("t1_m_data_now", 32'(bus.M_DATA), 32'h1234);
        wait_drain("t1", 50);

        // two requesters: alternating grants, one write per cycle
        glog.delete();
        gcyc.delete();
        for (int i = 0; i < 4; i++) begin
            src0.push_back(16'hA000 + 16'(i));
            src1.push_back(16'hB000 + 16'(i));
            sb.push_back(16'hA000 + 16'(i));
            sb.push_back(16'hB000 + 16'(i));
        end
        wait_drain("t2", 200);
        chk("t2_grants", 32'(glog.size()), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk($sformatf("t2_grant%0d", i), 32'(glog[i]), 32'(i % 2));
        if (gcyc.size() == 8) chk("t2_span", 32'(gcyc[7] - gcyc[0]), 7);

        // consumer stalled: FIFO fills to DEPTH plus the holding register
        @(posedge clk);
        #1;
        bus.M_READY = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            src0.push_back(16'h5500 + 16'(i));
            sb.push_back(16'h5500 + 16'(i));
        end
        repeat (40) @(negedge clk);
        chk("t3_acks_full", 32'(acks), 9);
        chk("t3_cnt_full", 32'(bus.CNT), 8);
        chk("t3_err_full", 32'(bus.ERR), 0);
        chk("t3_m_valid", 32'(bus.M_VALID), 1);
        chk("t3_req_pending", 32'(bus.REQ0), 1);
        chk("t3_no_ack", 32'(bus.ACK0), 0);
        chk("t3_no_wr", 32'(bus.F_WR), 0);
        @(posedge clk);
        #1;
        bus.M_READY = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_rd_at_full", 32'(bus.F_RD), 1);
        chk("t3_cnt_at_full", 32'(bus.CNT), 8);
        @(negedge clk);
        chk("t3_grant_on_read", 32'(bus.ACK0), 1);
        chk("t3_wr_on_read", 32'(bus.F_WR), 1);
        chk("t3_cnt_after", 32'(bus.CNT), 7);
        wait_drain("t3", 300);
        chk("t3_acks_total", 32'(acks), 10);
        chk("t3_err_end", 32'(bus.ERR), 0);

        // sticky error table
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            force_over = ev[i].ov;
            force_under = ev[i].un;
            bus.CLR_ERR = ev[i].clr;
            @(posedge clk);
            #1;
            force_over = 1'b0;
            force_under = 1'b0;
            bus.CLR_ERR = 1'b0;
            @(negedge clk);
            chk($sformatf("err_vec%0d", i), 32'(bus.ERR), 32'(ev[i].err));
        end
        @(posedge clk);
        #1;
        bus.CLR_ERR = 1'b1;
        @(posedge clk);
        #1;
        bus.CLR_ERR = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(bus.ERR), 0);

        // asynchronous reset while a read is pending with CNT=5
        @(posedge clk);
        #1;
        bus.M_READY = 1'b0;
        for (int i = 0; i < 7; i++) begin
            src0.push_back(16'h7700 + 16'(i));
            sb.push_back(16'h7700 + 16'(i));
        end
        repeat (30) @(negedge clk);
        chk("t5_cnt_pre", 32'(bus.CNT), 6);
        @(posedge clk);
        #1;
        bus.M_READY = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_cnt5", 32'(bus.CNT), 5);
        chk("t5_state", 32'(dut.state_q), 32'(R_PEND));
        #2;
        rstn = 1'b0;
        #1;
        chk_reset("async");
        sb.delete();
        src0.delete();
        src1.delete();
        @(negedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        src0.push_back(16'hBEEF);
        src1.push_back(16'hCAFE);
        sb.push_back(16'hBEEF);
        sb.push_back(16'hCAFE);
        wait_drain("t5", 100);
        chk("t5_err_end", 32'(bus.ERR), 0);
        chk("t5_cnt_end", 32'(bus.CNT), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
